// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline flow controller.
package pipe_pkg;

  localparam int          DEF_STAGES    = 5;
  localparam int          DEF_BIT_WIDTH = 32;
  localparam int          DEF_PC_STEP   = 4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pipe_state_e;

  typedef logic [DEF_STAGES-1:0] stage_mask_t;

endpackage

// File: rtl/pipe_ctrl_stall_resolver.sv
// Priority resolver: the highest valid stalling stage blocks itself and every
// stage in front of it; the stage just behind it receives a bubble.
module stall_resolver #(
  parameter int STAGES = 5
) (
  input  logic [STAGES-1:0] i_stall_req,
  input  logic [STAGES-1:0] i_valid,
  output logic [STAGES-1:0] o_enable,
  output logic [STAGES-1:0] o_bubble,
  output logic              o_any_stall
);

  logic [STAGES-1:0] w_blocked;

  always_comb begin
    logic w_blk;
    w_blk     = 1'b0;
    w_blocked = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      w_blk        = w_blk | (i_stall_req[i] & i_valid[i]);
      w_blocked[i] = w_blk;
    end
  end

  assign o_enable    = ~w_blocked;
  assign o_bubble    = {~w_blocked[STAGES-1:1] & w_blocked[STAGES-2:0], 1'b0};
  assign o_any_stall = w_blocked[0];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller: stage valid/enable, stall and flush handling, PC.
// Optional saturating perf counters behind PIPE_PERF_COUNTERS_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int                   STAGES       = DEF_STAGES,
  parameter int                   BIT_WIDTH    = DEF_BIT_WIDTH,
  parameter int                   FLUSH_STAGE  = 2,
  parameter int                   FLUSH_CYCLES = 1,
  parameter int                   PC_STEP      = DEF_PC_STEP,
  parameter logic [BIT_WIDTH-1:0] RESET_PC     = BIT_WIDTH'(DEF_RESET_PC)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic [STAGES-1:0]    i_stall_req,
  input  logic                 i_flush_req,
  input  logic [BIT_WIDTH-1:0] i_flush_pc,
  input  logic                 i_wb_pc_write,
  input  logic [BIT_WIDTH-1:0] i_wb_pc_value,
  output logic [STAGES-1:0]    o_stage_enable,
  output logic [STAGES-1:0]    o_stage_valid,
  output logic [BIT_WIDTH-1:0] o_pc,
  output logic                 o_flushing
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [31:0]          o_perf_cycles,
  output logic [31:0]          o_perf_stalls,
  output logic [31:0]          o_perf_flushes
`endif
);

  localparam logic [STAGES-1:0] FRONT_MASK =
    STAGES'((64'd1 << (FLUSH_STAGE + 1)) - 64'd1);
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  pipe_state_e          r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [STAGES-1:0]    r_valid, w_valid_nxt;
  logic [STAGES-1:0]    w_en, w_bubble, w_enable;
  logic [BIT_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                 w_any_stall, w_wb, w_flush_acc, w_in_flush;

  stall_resolver #(.STAGES(STAGES)) u_resolver (
    .i_stall_req (i_stall_req),
    .i_valid     (r_valid),
    .o_enable    (w_en),
    .o_bubble    (w_bubble),
    .o_any_stall (w_any_stall)
  );

  assign w_in_flush  = (r_state == ST_FLUSH);
  assign w_wb        = i_wb_pc_write & r_valid[STAGES-1];
  // A branch only counts once its instruction actually leaves the resolving stage.
  assign w_flush_acc = i_flush_req & ~w_in_flush & r_valid[FLUSH_STAGE] &
                       w_en[FLUSH_STAGE] & ~w_wb;

  always_comb begin
    w_enable = w_en;
    if (w_in_flush) w_enable = w_enable & ~FRONT_MASK;
    if (i_reset)    w_enable = '0;
  end

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_bubble[0])   w_valid_nxt[0] = 1'b0;
    else if (w_en[0])  w_valid_nxt[0] = i_run;
    for (int i = 1; i < STAGES; i++) begin
      if (w_bubble[i])     w_valid_nxt[i] = 1'b0;
      else if (w_en[i])    w_valid_nxt[i] = r_valid[i-1];
    end
    if (w_in_flush | w_flush_acc) w_valid_nxt = w_valid_nxt & ~FRONT_MASK;
    if (w_wb)                     w_valid_nxt[STAGES-2:0] = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_wb | w_flush_acc) begin
      w_state_nxt = ST_FLUSH;
      w_cnt_nxt   = CNT_LOAD;
    end else if (w_in_flush) begin
      if (r_cnt == 3'd0) w_state_nxt = ST_RUN;
      else               w_cnt_nxt   = r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_pc_nxt = r_pc + BIT_WIDTH'(PC_STEP);
    if (w_wb)                                   w_pc_nxt = i_wb_pc_value;
    else if (w_flush_acc)                       w_pc_nxt = i_flush_pc;
    else if (w_in_flush | w_any_stall | ~i_run) w_pc_nxt = r_pc;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
      r_valid <= '0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign o_stage_enable = w_enable;
  assign o_stage_valid  = r_valid;
  assign o_pc           = r_pc;
  assign o_flushing     = w_in_flush;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] r_perf_cycles, r_perf_stalls, r_perf_flushes;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_cycles  <= '0;
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (i_run && r_perf_cycles != '1)                  r_perf_cycles  <= r_perf_cycles + 32'd1;
      if (w_any_stall && r_perf_stalls != '1)            r_perf_stalls  <= r_perf_stalls + 32'd1;
      if ((w_wb | w_flush_acc) && r_perf_flushes != '1)  r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign o_perf_cycles  = r_perf_cycles;
  assign o_perf_stalls  = r_perf_stalls;
  assign o_perf_flushes = r_perf_flushes;
`endif

endmodule
